debounce_event_ctrl: RTL
========================

Name: debounce_event_ctrl

Overview:
Multi-channel debounce and event scheduler for GPIO/key inputs.
- Paces CH per-channel debounce state machines from one shared prescaled sample tick.
- Hold-compensated: release takes the same qualification delay as press, so debounced pulse width is preserved.
- Queues press/release events per channel and serialises them to the interrupt/APB side through one round-robin valid/ready port.

Parameters:
CH, 4, number of input channels (2..16)
WIDTH, 4, width of the delay_value tick counter
PRE_W, 8, width of the sample prescaler
CH_W, $clog2(CH), channel index width (derived, not overridable)

Ports:
clk  in  1  system clock
rstn  in  1  reset, asynchronous, active-low
enable  in  1  block enable; low = synchronous abort/clear
prescale  in  PRE_W  sample tick period minus 1 (0 = tick every clk)
delay_value  in  WIDTH  consecutive ticks required to qualify an edge
polarity  in  CH  active level per channel (1 = active-high)
din  in  CH  raw inputs, already 2-flop synchronised upstream
level  out  CH  debounced active state per channel
evt_valid  out  1  event available
evt_ready  in  1  consumer accepts event
evt_ch  out  CH_W  channel of presented event
evt_rise  out  1  1 = press (became active), 0 = release
evt_drop  out  CH  sticky: event lost on channel (pending overwritten)
drop_clr  in  CH  write-1 pulse clears evt_drop bits

Behaviour:
- Reset values: level=0, evt_valid=0, evt_ch=0, evt_rise=0, evt_drop=0; prescaler=0; all FSMs RELEASED; counters=0; RR pointer=0.
- Prescaler counts 0..prescale. tick asserts for one clk when count==prescale, then wraps to 0.
- prescale change mid-count: if count>prescale, wrap to 0 next clk with no tick.
- act[i] = (din[i]==polarity[i]). FSM and counter change only on tick cycles.
- Per-channel FSM; states RELEASED, PRESS_CHK, PRESSED, REL_CHK:
  - RELEASED: tick & act -> PRESS_CHK, cnt=1. If delay_value<=1, go straight to PRESSED instead.
  - PRESS_CHK: tick & !act -> RELEASED, cnt=0. tick & act: cnt+1; when cnt+1==delay_value -> PRESSED.
  - PRESSED: tick & !act -> REL_CHK, cnt=1. If delay_value<=1, go straight to RELEASED.
  - REL_CHK: tick & act -> PRESSED, cnt=0. tick & !act: cnt+1; when cnt+1==delay_value -> RELEASED.
  - delay_value changed mid-check: comparison is ==. If cnt has already passed the new value, cnt wraps modulo 2^WIDTH; no saturation.
- level[i] is registered: high in PRESSED/REL_CHK. It changes the clk after the qualifying tick.
- Event generation, same clk as the level change:
  - pend[i] set; pend_rise[i] = new level.
  - If pend[i] was already set and is not being accepted this clk: overwrite pend_rise and set evt_drop[i].
- Output scheduler:
  - Not valid: pick the first pend bit at or after the RR pointer; register evt_valid/evt_ch/evt_rise the next clk. Minimum latency level->evt_valid = 1 clk.
  - evt_valid high: evt_ch/evt_rise are held stable until evt_valid&evt_ready. The presented pend_rise is sampled into the output register at grant; later overwrites do not change the presented data.
  - Handshake clk: pend[evt_ch] cleared and pointer = evt_ch+1 (mod CH). evt_valid may re-assert the very next clk.
  - New event on the granted channel in the handshake clk: set wins, pend stays 1, no drop flagged.
- evt_drop: set has priority over same-clk drop_clr.
- enable=0 (synchronous):
  - FSMs -> RELEASED; level=0; pend=0; evt_valid=0; prescaler=0.
  - evt_drop retained; no events generated for the forced release.
  - This is the one case where evt_valid deasserts without ready.
- Async reset mid-operation: all state returns to reset values immediately.

Decomposition:
- Package debounce_pkg: FSM state encoding (2-bit: RELEASED=0, PRESS_CHK=1, PRESSED=2, REL_CHK=3) and an EVT_PRESS/EVT_RELEASE constant pair.
- Sub-module debounce_channel_fsm: one channel's FSM, counter, level and pend/drop flags; instantiated CH times by generate.
- Prescaler and round-robin picker stay in the top.

Test Plan:
- Basic press, prescale=0, delay_value=3, polarity=1: din[0] high for 3 clk -> level[0]=1 one clk later; evt_valid with evt_ch=0, evt_rise=1 next clk; a 2-clk glitch produces no event.
- Hold compensation: prescale=0, delay_value=4, din[1] high 10 clk -> level[1] high for exactly 10 clk, shifted 4 clk later; rise and fall events both delivered.
- Prescaled: prescale=3, delay_value=2 -> qualification needs 2 ticks (8 clk window); input toggling between ticks is ignored.
- Round-robin: ch0, ch2, ch3 qualify in the same clk, evt_ready=1 -> events in order 0,2,3 on consecutive clks. Repeat with the pointer left at 3 -> order 3,0,2.
- Backpressure/drop: evt_ready=0, ch1 press then release -> evt_drop[1]=1, pending reports release (evt_rise=0); drop_clr[1] clears it.
- enable dropped while evt_valid=1 and level=4'b0101 -> next clk evt_valid=0, level=0, no new event; evt_drop preserved. Async rstn pulse mid-check -> all outputs 0.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg
// Shared definitions for the multi-channel debounce / event controller:
//   deb_state_t  - per-channel debounce FSM state encoding
//   EVT_PRESS    - event polarity value for "became active"
//   EVT_RELEASE  - event polarity value for "became inactive"
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } deb_state_t;

  localparam logic EVT_PRESS   = 1'b1;
  localparam logic EVT_RELEASE = 1'b0;

endpackage

// File: rtl/debounce_channel_fsm.sv
// debounce_channel_fsm
// One channel of the debouncer: qualification FSM, tick counter, debounced
// level and the pending-event / sticky-drop flags.
// Ports:
//   clk, rstn    clock, asynchronous active-low reset
//   enable       low = force RELEASED and discard pending event (drop kept)
//   tick         shared sample tick
//   act          input is at its active level this cycle
//   delay_value  consecutive ticks required to qualify an edge
//   accept       pending event of this channel is handed off this clk
//   drop_clr     clears the sticky drop flag
//   level        debounced active state
//   pend         event waiting for the scheduler
//   pend_rise    polarity of the waiting event
//   drop         sticky: a pending event was overwritten
module debounce_channel_fsm
  import debounce_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic             tick,
  input  logic             act,
  input  logic [WIDTH-1:0] delay_value,
  input  logic             accept,
  input  logic             drop_clr,
  output logic             level,
  output logic             pend,
  output logic             pend_rise,
  output logic             drop
);

  deb_state_t       state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_inc;
  logic             short_delay;
  logic             press_qual;
  logic             rel_qual;
  logic             evt;

  // Counter wraps modulo 2^WIDTH; equality compare means a shrunken
  // delay_value is only met again after a full wrap.
  assign cnt_inc     = cnt + WIDTH'(1);
  assign short_delay = (delay_value <= WIDTH'(1));

  // Edges that change the debounced level (and so produce an event).
  assign press_qual = tick && act &&
                      ((state == ST_RELEASED && short_delay) ||
                       (state == ST_PRESS_CHK && cnt_inc == delay_value));
  assign rel_qual   = tick && !act &&
                      ((state == ST_PRESSED && short_delay) ||
                       (state == ST_REL_CHK && cnt_inc == delay_value));
  assign evt        = press_qual || rel_qual;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_RELEASED;
      cnt       <= '0;
      level     <= 1'b0;
      pend      <= 1'b0;
      pend_rise <= 1'b0;
      drop      <= 1'b0;
    end else if (!enable) begin
      state <= ST_RELEASED;
      cnt   <= '0;
      level <= 1'b0;
      pend  <= 1'b0;
      if (drop_clr) drop <= 1'b0;
    end else begin
      if (tick) begin
        case (state)
          ST_RELEASED: begin
            if (act) begin
              if (short_delay) begin
                state <= ST_PRESSED;
                level <= 1'b1;
              end else begin
                state <= ST_PRESS_CHK;
                cnt   <= WIDTH'(1);
              end
            end
          end
          ST_PRESS_CHK: begin
            if (!act) begin
              state <= ST_RELEASED;
              cnt   <= '0;
            end else if (press_qual) begin
              state <= ST_PRESSED;
              cnt   <= '0;
              level <= 1'b1;
            end else begin
              cnt <= cnt_inc;
            end
          end
          ST_PRESSED: begin
            if (!act) begin
              if (short_delay) begin
                state <= ST_RELEASED;
                level <= 1'b0;
              end else begin
                state <= ST_REL_CHK;
                cnt   <= WIDTH'(1);
              end
            end
          end
          default: begin // ST_REL_CHK
            if (act) begin
              state <= ST_PRESSED;
              cnt   <= '0;
            end else if (rel_qual) begin
              state <= ST_RELEASED;
              cnt   <= '0;
              level <= 1'b0;
            end else begin
              cnt <= cnt_inc;
            end
          end
        endcase
      end

      // A new event wins over a same-clk accept of the old one.
      if (evt) begin
        pend      <= 1'b1;
        pend_rise <= press_qual ? EVT_PRESS : EVT_RELEASE;
      end else if (accept) begin
        pend <= 1'b0;
      end

      if (evt && pend && !accept) drop <= 1'b1;
      else if (drop_clr)          drop <= 1'b0;
    end
  end

endmodule

// File: rtl/debounce_event_ctrl.sv
// debounce_event_ctrl
// Multi-channel debounce with a shared sample prescaler and a round-robin
// valid/ready event port.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   enable         low = synchronous abort/clear (evt_drop kept)
//   prescale       sample tick period minus 1
//   delay_value    consecutive ticks required to qualify an edge
//   polarity       active level per channel (1 = active-high)
//   din            synchronised raw inputs
//   level          debounced active state per channel
//   evt_valid/evt_ready/evt_ch/evt_rise  event handshake port
//   evt_drop       sticky per-channel lost-event flags
//   drop_clr       write-1 pulse clearing evt_drop bits
module debounce_event_ctrl
  import debounce_pkg::*;
#(
  parameter  int CH    = 4,
  parameter  int WIDTH = 4,
  parameter  int PRE_W = 8,
  localparam int CH_W  = $clog2(CH)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             enable,
  input  logic [PRE_W-1:0] prescale,
  input  logic [WIDTH-1:0] delay_value,
  input  logic [CH-1:0]    polarity,
  input  logic [CH-1:0]    din,
  output logic [CH-1:0]    level,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CH_W-1:0]  evt_ch,
  output logic             evt_rise,
  output logic [CH-1:0]    evt_drop,
  input  logic [CH-1:0]    drop_clr
);

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;
  logic [CH-1:0]    act;
  logic [CH-1:0]    pend;
  logic [CH-1:0]    pend_rise;
  logic [CH-1:0]    accept;
  logic [CH-1:0]    cand;
  logic [CH_W-1:0]  ptr;
  logic [CH_W-1:0]  ch_inc;
  logic [CH_W-1:0]  base;
  logic [CH_W-1:0]  pick_idx;
  logic             pick_found;
  logic             hs;

  // Prescaler: a count above a freshly lowered prescale wraps without a tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                            pre_cnt <= '0;
    else if (!enable || pre_cnt >= prescale) pre_cnt <= '0;
    else                                  pre_cnt <= pre_cnt + PRE_W'(1);
  end

  assign tick = enable && (pre_cnt == prescale);
  assign act  = ~(din ^ polarity);
  assign hs   = evt_valid && evt_ready;

  genvar gi;
  for (gi = 0; gi < CH; gi++) begin : g_ch
    assign accept[gi] = hs && (evt_ch == CH_W'(gi));

    debounce_channel_fsm #(.WIDTH(WIDTH)) u_fsm (
      .clk        (clk),
      .rstn       (rstn),
      .enable     (enable),
      .tick       (tick),
      .act        (act[gi]),
      .delay_value(delay_value),
      .accept     (accept[gi]),
      .drop_clr   (drop_clr[gi]),
      .level      (level[gi]),
      .pend       (pend[gi]),
      .pend_rise  (pend_rise[gi]),
      .drop       (evt_drop[gi])
    );
  end

  // On a handshake the search already starts past the granted channel and
  // excludes it, so the next event can be presented back-to-back.
  assign ch_inc = (int'(evt_ch) == CH - 1) ? '0 : evt_ch + CH_W'(1);
  assign base   = hs ? ch_inc : ptr;
  assign cand   = pend & ~accept;

  always_comb begin : pick_blk
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < CH; k++) begin
      idx = int'(base) + k;
      if (idx >= CH) idx = idx - CH;
      if (!pick_found && cand[idx]) begin
        pick_found = 1'b1;
        pick_idx   = CH_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      evt_rise  <= 1'b0;
      ptr       <= '0;
    end else if (!enable) begin
      evt_valid <= 1'b0;
    end else begin
      if (hs) ptr <= ch_inc;
      // Output data is captured at grant and held while the consumer stalls.
      if (!evt_valid || hs) begin
        evt_valid <= pick_found;
        if (pick_found) begin
          evt_ch   <= pick_idx;
          evt_rise <= pend_rise[pick_idx];
        end
      end
    end
  end

endmodule
